// File: rtl/live_gate_sequencer.sv
// Spill-cycle controller for the live-ratio counter pair: clears the counters, opens
// a live window between spill pulses, drains, then snapshots results for readout.
module live_gate_sequencer #(
  parameter int unsigned START_DLY = 16,
  parameter int unsigned DRAIN_DLY = 8,
  parameter logic [31:0] MAX_LIVE  = 32'd100_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spill_start,
  input  logic        spill_end,
  input  logic        daq_busy,
  input  logic [31:0] n_in,
  input  logic [31:0] n_out,
  output logic        live,
  output logic        cnt_rst,
  output logic        snap_valid,
  input  logic        snap_ready,
  output logic [31:0] snap_n_in,
  output logic [31:0] snap_n_out,
  output logic [31:0] snap_live_cycles,
  output logic [31:0] snap_busy_cycles,
  output logic [15:0] snap_spill_id,
  output logic        snap_timeout,
  output logic [7:0]  missed_spills,
  output logic [2:0]  state
);
  typedef enum logic [2:0] {
    IDLE = 3'd0, CLEAR = 3'd1, ARM = 3'd2, LIVE = 3'd3,
    DRAIN = 3'd4, SNAP = 3'd5, WAIT_ACK = 3'd6
  } state_t;

  localparam logic [31:0] START_LAST = 32'(START_DLY - 1);
  localparam logic [31:0] DRAIN_LAST = 32'(DRAIN_DLY - 1);

  state_t      st;
  logic [31:0] dly;
  logic [31:0] live_cycles;
  logic [31:0] busy_cycles;
  logic [31:0] live_nxt;
  logic        timeout;
  logic [15:0] spill_id;

  assign live_nxt = (live_cycles == '1) ? live_cycles : live_cycles + 32'd1;
  assign live     = (st == LIVE);
  assign cnt_rst  = (st == CLEAR);
  assign state    = st;

  always_ff @(posedge clk) begin
    if (rst) begin
      st               <= IDLE;
      dly              <= '0;
      live_cycles      <= '0;
      busy_cycles      <= '0;
      timeout          <= 1'b0;
      spill_id         <= '0;
      missed_spills    <= '0;
      snap_valid       <= 1'b0;
      snap_n_in        <= '0;
      snap_n_out       <= '0;
      snap_live_cycles <= '0;
      snap_busy_cycles <= '0;
      snap_spill_id    <= '0;
      snap_timeout     <= 1'b0;
    end else begin
      // A new spill cannot be served until the previous snapshot has been taken.
      if (spill_start && (st == DRAIN || st == SNAP || st == WAIT_ACK) && missed_spills != 8'hFF)
        missed_spills <= missed_spills + 8'd1;
      case (st)
        IDLE: if (spill_start && !spill_end) st <= CLEAR;
        CLEAR: begin
          live_cycles <= '0;
          busy_cycles <= '0;
          timeout     <= 1'b0;
          dly         <= '0;
          st          <= ARM;
        end
        ARM: begin
          if (spill_end) begin
            dly <= '0;
            st  <= DRAIN;
          end else if (dly == START_LAST) begin
            dly <= '0;
            st  <= LIVE;
          end else begin
            dly <= dly + 32'd1;
          end
        end
        LIVE: begin
          live_cycles <= live_nxt;
          if (daq_busy && busy_cycles != '1) busy_cycles <= busy_cycles + 32'd1;
          dly <= '0;
          // Timeout wins the flag even when spill_end lands on the same cycle.
          if (live_nxt >= MAX_LIVE) begin
            timeout <= 1'b1;
            st      <= DRAIN;
          end else if (spill_end) begin
            st <= DRAIN;
          end
        end
        DRAIN: begin
          if (dly == DRAIN_LAST) st <= SNAP;
          else dly <= dly + 32'd1;
        end
        SNAP: begin
          snap_n_in        <= n_in;
          snap_n_out       <= n_out;
          snap_live_cycles <= live_cycles;
          snap_busy_cycles <= busy_cycles;
          snap_spill_id    <= spill_id;
          snap_timeout     <= timeout;
          snap_valid       <= 1'b1;
          st               <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (snap_ready) begin
            snap_valid <= 1'b0;
            spill_id   <= spill_id + 16'd1;
            st         <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_live_gate_sequencer.sv
// Directed bench for live_gate_sequencer; snapshot expectations go through a queue
// and are popped when snap_valid rises at its predicted cycle.
module tb_live_gate_sequencer;
  logic        clk = 1'b0;
  logic        rst, spill_start, spill_end, daq_busy, snap_ready;
  logic [31:0] n_in, n_out;
  logic        live, cnt_rst, snap_valid, snap_timeout;
  logic [31:0] snap_n_in, snap_n_out, snap_live_cycles, snap_busy_cycles;
  logic [15:0] snap_spill_id;
  logic [7:0]  missed_spills;
  logic [2:0]  state;

  typedef struct {
    logic [31:0] ni, no, lc, bc;
    logic [15:0] id;
    logic        to;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_id = '0;

  live_gate_sequencer #(.START_DLY(16), .DRAIN_DLY(8), .MAX_LIVE(32'd1000)) dut (
    .clk(clk), .rst(rst), .spill_start(spill_start), .spill_end(spill_end),
    .daq_busy(daq_busy), .n_in(n_in), .n_out(n_out), .live(live), .cnt_rst(cnt_rst),
    .snap_valid(snap_valid), .snap_ready(snap_ready), .snap_n_in(snap_n_in),
    .snap_n_out(snap_n_out), .snap_live_cycles(snap_live_cycles),
    .snap_busy_cycles(snap_busy_cycles), .snap_spill_id(snap_spill_id),
    .snap_timeout(snap_timeout), .missed_spills(missed_spills), .state(state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] ni, input logic [31:0] no, input logic [31:0] lc,
                          input logic [31:0] bc, input logic to);
    exp_t e;
    e.ni = ni; e.no = no; e.lc = lc; e.bc = bc; e.id = exp_id; e.to = to;
    sb.push_back(e);
  endtask

  task automatic chk_fields(input string tag, input exp_t e);
    chk({tag, "_n_in"},  snap_n_in, e.ni);
    chk({tag, "_n_out"}, snap_n_out, e.no);
    chk({tag, "_live"},  snap_live_cycles, e.lc);
    chk({tag, "_busy"},  snap_busy_cycles, e.bc);
    chk({tag, "_id"},    32'(snap_spill_id), 32'(e.id));
    chk({tag, "_to"},    32'(snap_timeout), 32'(e.to));
  endtask

  // Called in IDLE; returns in the first ARM cycle.
  task automatic pulse_start();
    spill_start = 1'b1;
    tick();
    spill_start = 1'b0;
    chk("cnt_rst_on", 32'(cnt_rst), 1);
    chk("state_clear", 32'(state), 1);
    tick();
    chk("cnt_rst_off", 32'(cnt_rst), 0);
    chk("live_arm", 32'(live), 0);
  endtask

  // From the first ARM cycle, live must rise exactly START_DLY cycles later.
  task automatic wait_live();
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("live_pre", 32'(live), 0);
    end
    tick();
    chk("live_rise", 32'(live), 1);
  endtask

  // Called in the first live cycle; live spans n cycles, busy on cycles [bf, bf+bl).
  task automatic hold_live(input int n, input int bf, input int bl);
    for (int j = 1; j < n; j++) begin
      tick();
      chk("live_hold", 32'(live), 1);
      daq_busy = (j >= bf && j < bf + bl);
    end
    spill_end = 1'b1;
    daq_busy  = 1'b0;
    tick();
    spill_end = 1'b0;
    chk("live_fall", 32'(live), 0);
  endtask

  // Called in the first DRAIN cycle; snap_valid must rise DRAIN_DLY+1 cycles later.
  task automatic expect_drain(output exp_t e);
    chk("drain_valid", 32'(snap_valid), 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("drain_valid", 32'(snap_valid), 0);
      chk("drain_live", 32'(live), 0);
    end
    tick();
    chk("snap_valid_rise", 32'(snap_valid), 1);
    chk("sb_nonempty", 32'(sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk_fields("snap", e);
    end else begin
      e = '{default: '0};
    end
  endtask

  // Handshake with snap_ready already high.
  task automatic ack();
    tick();
    chk("ack_valid", 32'(snap_valid), 0);
    chk("ack_state", 32'(state), 0);
    exp_id = exp_id + 16'd1;
  endtask

  task automatic run_spill(input logic [31:0] ni, input logic [31:0] no, input int n,
                           input int bf, input int bl, output exp_t e);
    n_in  = ni;
    n_out = no;
    pulse_start();
    wait_live();
    push_exp(ni, no, 32'(n), 32'(bl), 1'b0);
    hold_live(n, bf, bl);
    expect_drain(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst    = 1'b0;
    exp_id = '0;
  endtask

  initial begin
    exp_t e;
    rst = 1'b1; spill_start = 1'b0; spill_end = 1'b0; daq_busy = 1'b0;
    snap_ready = 1'b1; n_in = '0; n_out = '0;
    do_reset();
    chk("rst_live", 32'(live), 0);
    chk("rst_cnt_rst", 32'(cnt_rst), 0);
    chk("rst_valid", 32'(snap_valid), 0);
    chk("rst_state", 32'(state), 0);
    chk("rst_missed", 32'(missed_spills), 0);
    chk("rst_snap_live", snap_live_cycles, 0);
    chk("rst_snap_id", 32'(snap_spill_id), 0);
    repeat (5) tick();

    // 1. nominal spill: live 28..510 -> 483 cycles
    run_spill(32'd300, 32'd290, 483, 0, 0, e);
    ack();
    repeat (3) tick();

    // 2. busy accounting, 50 busy cycles inside LIVE
    run_spill(32'd1234, 32'd1200, 483, 100, 50, e);
    ack();
    repeat (3) tick();

    // 3. timeout: live exactly 1000 cycles
    n_in = 32'd77; n_out = 32'd66;
    pulse_start();
    wait_live();
    push_exp(32'd77, 32'd66, 32'd1000, 32'd0, 1'b1);
    for (int j = 1; j < 1000; j++) begin
      tick();
      chk("to_live", 32'(live), 1);
    end
    tick();
    chk("to_live_fall", 32'(live), 0);
    expect_drain(e);
    ack();
    chk("missed_none", 32'(missed_spills), 0);

    // 4. backpressure with two dropped spills
    do_reset();
    snap_ready = 1'b0;
    run_spill(32'hDEAD_BEEF, 32'h0BAD_F00D, 40, 5, 7, e);
    for (int i = 1; i <= 200; i++) begin
      spill_start = (i == 50 || i == 120);
      tick();
      chk("bp_valid", 32'(snap_valid), 1);
      chk_fields("bp", e);
    end
    spill_start = 1'b0;
    chk("bp_state", 32'(state), 6);
    chk("bp_missed", 32'(missed_spills), 2);
    snap_ready = 1'b1;
    ack();
    run_spill(32'd10, 32'd9, 20, 0, 0, e);
    ack();
    chk("missed_kept", 32'(missed_spills), 2);

    // 5A. spill_end during ARM
    n_in = 32'd5; n_out = 32'd4;
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("arm_live", 32'(live), 0);
    end
    push_exp(32'd5, 32'd4, 32'd0, 32'd0, 1'b0);
    spill_end = 1'b1;
    tick();
    spill_end = 1'b0;
    chk("arm_end_state", 32'(state), 4);
    expect_drain(e);
    ack();

    // 5B. coincident pulses in IDLE are ignored
    spill_start = 1'b1; spill_end = 1'b1;
    tick();
    spill_start = 1'b0; spill_end = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("both_state", 32'(state), 0);
      chk("both_cnt_rst", 32'(cnt_rst), 0);
      tick();
    end

    // 6. reset mid-LIVE aborts without a snapshot
    n_in = 32'd1; n_out = 32'd1;
    pulse_start();
    wait_live();
    for (int j = 1; j < 100; j++) tick();
    rst = 1'b1;
    tick();
    rst    = 1'b0;
    exp_id = '0;
    chk("mid_rst_live", 32'(live), 0);
    chk("mid_rst_valid", 32'(snap_valid), 0);
    chk("mid_rst_state", 32'(state), 0);
    chk("mid_rst_id", 32'(snap_spill_id), 0);
    chk("mid_rst_missed", 32'(missed_spills), 0);
    repeat (20) begin
      tick();
      chk("mid_rst_novalid", 32'(snap_valid), 0);
    end
    run_spill(32'd555, 32'd444, 30, 3, 4, e);
    ack();
    chk("sb_drained", 32'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
